choreo_ctrl_frontend: RTL



---
 rtl/choreo_ctrl_frontend.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/choreo_ctrl_frontend.sv
// Board-side control front end for the LED pattern generator.
// Synchronises and debounces buttons and switches, then tracks pattern, speed, pause and demo.
module choreo_ctrl_frontend #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DEMO_TICKS      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_pause,
    input  logic       btn_speed,
    input  logic       sw_enable,
    input  logic       sw_demo,
    output logic [2:0] pat_sel,
    output logic       speed_sel,
    output logic       pause,
    output logic       ena,
    output logic       pat_changed
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TW = $clog2(DEMO_TICKS) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TK_LAST = TW'(DEMO_TICKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [5:0] raw;
    logic [5:0] sync1;
    logic [5:0] sync2;
    logic [5:0] lvl;
    logic [5:0] flip;
    logic [3:0] arm;
    logic [3:0] ev;
    logic [1:0] prime;

    assign raw = {sw_demo, sw_enable, btn_speed, btn_pause, btn_prev, btn_next};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prime <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prime <= {prime[0], 1'b1};
        end
    end

    for (genvar i = 0; i < 6; i++) begin : g_db
        logic [DW-1:0] cnt;
        logic          lvl_q;

        assign flip[i] = (sync2[i] != lvl_q) && (cnt == DB_LAST);
        assign lvl[i]  = lvl_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt   <= '0;
                lvl_q <= 1'b0;
            end else if (sync2[i] == lvl_q) begin
                cnt <= '0;
            end else if (flip[i]) begin
                cnt   <= '0;
                lvl_q <= ~lvl_q;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end
    end

    // A button only arms once the synchroniser has seen it released after reset,
    // so a button held through reset cannot fire an event.
    for (genvar i = 0; i < 4; i++) begin : g_ev
        logic arm_q;
        logic ev_q;

        assign arm[i] = arm_q;
        assign ev[i]  = ev_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                arm_q <= 1'b0;
                ev_q  <= 1'b0;
            end else begin
                arm_q <= arm_q | (prime[1] & ~sync2[i]);
                ev_q  <= flip[i] & ~lvl[i] & arm_q;
            end
        end
    end

    logic [2:0]    pat_q;
    logic [2:0]    pat_d;
    logic          spd_q;
    logic          spd_d;
    logic          pse_q;
    logic          pse_d;
    logic          chg_q;
    logic          chg_d;
    logic [TW-1:0] tcnt_q;
    logic [TW-1:0] tcnt_d;
    logic [1:0]    st_q;
    logic [1:0]    st_d;
    logic          demo_nx;
    logic          ena_nx;
    logic          man;
    logic          wrap;

    assign demo_nx = lvl[5] ^ flip[5];
    assign ena_nx  = lvl[4] ^ flip[4];
    assign man     = lvl[4] & (ev[0] ^ ev[1]);
    assign wrap    = (st_q == S_RUN) && (tcnt_q == TK_LAST);

    always_comb begin
        pse_d  = pse_q ^ ev[2];
        spd_d  = spd_q ^ ev[3];
        pat_d  = pat_q;
        chg_d  = 1'b0;
        tcnt_d = tcnt_q;
        unique case (st_q)
            S_RUN:   tcnt_d = wrap ? '0 : tcnt_q + TW'(1);
            S_HOLD:  tcnt_d = tcnt_q;
            default: tcnt_d = '0;
        endcase
        // Manual step wins over a coincident demo wrap.
        if (man) begin
            pat_d  = ev[0] ? pat_q + 3'd1 : pat_q - 3'd1;
            chg_d  = 1'b1;
            tcnt_d = '0;
        end else if (wrap) begin
            pat_d = pat_q + 3'd1;
            chg_d = 1'b1;
        end
        if (!demo_nx) begin
            st_d = S_IDLE;
        end else if (pse_d || !ena_nx) begin
            st_d = S_HOLD;
        end else begin
            st_d = S_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= '0;
            spd_q  <= 1'b0;
            pse_q  <= 1'b0;
            chg_q  <= 1'b0;
            tcnt_q <= '0;
            st_q   <= S_IDLE;
        end else begin
            pat_q  <= pat_d;
            spd_q  <= spd_d;
            pse_q  <= pse_d;
            chg_q  <= chg_d;
            tcnt_q <= tcnt_d;
            st_q   <= st_d;
        end
    end

    assign pat_sel     = pat_q;
    assign speed_sel   = spd_q;
    assign pause       = pse_q;
    assign ena         = lvl[4];
    assign pat_changed = chg_q;

endmodule
